// File: rtl/regfile_scoreboard.sv
// Parametrised NUM_RD-read / 1-write register file with a per-register busy scoreboard.
// Define REGFILE_BYPASS_EN for same-cycle write-to-read forwarding. Without it, reads return the pre-write value.
module regfile_scoreboard #(
  parameter  int XLEN   = 32,
  parameter  int NREG   = 32,
  parameter  int NUM_RD = 2,
  localparam int AW     = $clog2(NREG)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   WE3,
  input  logic [AW-1:0]          A3,
  input  logic [XLEN-1:0]        WD3,
  input  logic [NUM_RD*AW-1:0]   A_RD,
  output logic [NUM_RD*XLEN-1:0] RD,
  input  logic                   BUSY_SET,
  input  logic [AW-1:0]          A_BUSY,
  output logic [NUM_RD-1:0]      RD_BUSY,
  output logic                   ANY_BUSY,
  output logic [AW:0]            BUSY_CNT
);

  logic [XLEN-1:0] r_regs [NREG];
  logic [NREG-1:0] r_busy;
  logic            w_wr_en;

  assign w_wr_en = WE3 && (A3 != '0);

  // Entry 0 is never written, so the hardwired zero and the constant busy[0] come for free.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      // NOTE: the array is reset explicitly because reset must visibly clear every register. That keeps it in flops, not a RAM macro.
      for (int r = 0; r < NREG; r++) r_regs[r] <= '0;
      r_busy <= '0;
    end else begin
      // NOTE: non-blocking assignments, so every flop samples the pre-edge values.
      if (w_wr_en) r_regs[A3] <= WD3;
      for (int r = 1; r < NREG; r++) begin
        if (BUSY_SET && (A_BUSY == AW'(r)))
          r_busy[r] <= 1'b1;
        else if (w_wr_en && (A3 == AW'(r)))
          r_busy[r] <= 1'b0;
      end
    end
  end

  always_comb begin
    // NOTE: defaults first, so no path leaves an output unassigned and no latch is inferred.
    RD      = '0;
    RD_BUSY = '0;
    for (int i = 0; i < NUM_RD; i++) begin
      RD[i*XLEN +: XLEN] = r_regs[A_RD[i*AW +: AW]];
      RD_BUSY[i]         = r_busy[A_RD[i*AW +: AW]];
`ifdef REGFILE_BYPASS_EN
      // Gated by rst so a write presented during reset cannot leak onto RD.
      if (rst && w_wr_en && (A_RD[i*AW +: AW] == A3)) begin
        RD[i*XLEN +: XLEN] = WD3;
        RD_BUSY[i]         = 1'b0;
      end
`endif
    end
  end

  always_comb begin
    BUSY_CNT = '0;
    for (int r = 0; r < NREG; r++) BUSY_CNT = BUSY_CNT + (AW+1)'(r_busy[r]);
  end

  assign ANY_BUSY = |r_busy;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Scoreboard bench for regfile_scoreboard: the driver pushes model-predicted outputs and a monitor compares at negedge.
// Honours REGFILE_BYPASS_EN so the model matches the build of the design.
module tb_regfile_scoreboard;
  localparam int XLEN   = 32;
  localparam int NREG   = 32;
  localparam int NUM_RD = 2;
  localparam int AW     = $clog2(NREG);
`ifdef REGFILE_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   we3;
  logic [AW-1:0]          a3;
  logic [XLEN-1:0]        wd3;
  logic [NUM_RD*AW-1:0]   ard;
  logic [NUM_RD*XLEN-1:0] rd;
  logic                   bset;
  logic [AW-1:0]          abusy;
  logic [NUM_RD-1:0]      rd_busy;
  logic                   any_busy;
  logic [AW:0]            busy_cnt;

  regfile_scoreboard #(.XLEN(XLEN), .NREG(NREG), .NUM_RD(NUM_RD)) dut (
    .clk(clk), .rst(rst), .WE3(we3), .A3(a3), .WD3(wd3), .A_RD(ard), .RD(rd),
    .BUSY_SET(bset), .A_BUSY(abusy), .RD_BUSY(rd_busy), .ANY_BUSY(any_busy),
    .BUSY_CNT(busy_cnt)
  );

  always #5 clk = ~clk;

  // Architectural model: register values and the set of registers with a pending producer.
  logic [XLEN-1:0] m_regs [NREG];
  bit              m_busy [NREG];

  typedef struct {
    string                  name;
    logic [NUM_RD*XLEN-1:0] rd;
    logic [NUM_RD-1:0]      rbusy;
    logic                   any;
    logic [AW:0]            cnt;
  } exp_t;
  exp_t q[$];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic void model_clear();
    for (int r = 0; r < NREG; r++) begin
      m_regs[r] = '0;
      m_busy[r] = 1'b0;
    end
  endfunction

  // Applies the effect of one rising edge with the inputs currently presented.
  function automatic void model_update();
    if (!rst) return;
    if (we3 && a3 != 0) begin
      m_regs[a3] = wd3;
      m_busy[a3] = 1'b0;
    end
    if (bset && abusy != 0) m_busy[abusy] = 1'b1;
  endfunction

  function automatic void push_expect(input string name);
    exp_t e;
    int   cnt = 0;
    e.name  = name;
    e.rd    = '0;
    e.rbusy = '0;
    for (int r = 0; r < NREG; r++) if (m_busy[r]) cnt++;
    if (!rst) cnt = 0;
    for (int i = 0; i < NUM_RD; i++) begin
      int a = int'(ard[i*AW +: AW]);
      if (!rst) continue;
      if (BYPASS && we3 && a3 != 0 && a == int'(a3)) begin
        e.rd[i*XLEN +: XLEN] = wd3;
      end else begin
        e.rd[i*XLEN +: XLEN] = (a == 0) ? '0 : m_regs[a];
        e.rbusy[i]           = m_busy[a];
      end
    end
    e.cnt = (AW+1)'(cnt);
    e.any = (cnt != 0);
    q.push_back(e);
  endfunction

  function automatic logic [NUM_RD*AW-1:0] ards(input int a0, input int a1);
    logic [NUM_RD*AW-1:0] v;
    for (int i = 0; i < NUM_RD; i++)
      v[i*AW +: AW] = AW'((i == 0) ? a0 : ((i == 1) ? a1 : (a0 + i) % NREG));
    return v;
  endfunction

  task automatic cycle(input bit we, input int wa, input logic [XLEN-1:0] wd,
                       input bit bs, input int ba, input logic [NUM_RD*AW-1:0] rda,
                       input string name);
    @(posedge clk);
    model_update();
    #1;
    rst   = 1'b1;
    we3   = we;
    a3    = AW'(wa);
    wd3   = wd;
    bset  = bs;
    abusy = AW'(ba);
    ard   = rda;
    push_expect(name);
  endtask

  // Drops reset between edges with the previous inputs still applied.
  task automatic async_reset(input string name);
    @(posedge clk);
    model_update();
    #2;
    rst = 1'b0;
    model_clear();
    push_expect(name);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() != 0) begin
        e = q.pop_front();
        check({e.name, ".rd"},       256'(rd),       256'(e.rd));
        check({e.name, ".rd_busy"},  256'(rd_busy),  256'(e.rbusy));
        check({e.name, ".any_busy"}, 256'(any_busy), 256'(e.any));
        check({e.name, ".busy_cnt"}, 256'(busy_cnt), 256'(e.cnt));
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin : driver
    logic [NUM_RD*AW-1:0] ra;
    rst = 1'b0; we3 = 1'b0; a3 = '0; wd3 = '0; bset = 1'b0; abusy = '0;
    ard = ards(1, 0);
    model_clear();
    #1 push_expect("reset");
    #11 rst = 1'b1;

    cycle(1, 1, 100, 0, 0, ards(0, 0), "wr_x1");
    cycle(1, 0, 5,   0, 0, ards(1, 0), "rd_x1_wr_x0");
    cycle(0, 0, 0,   0, 0, ards(0, 1), "rd_x0");

    cycle(1, 5, 7,   0, 0, ards(0, 0), "wr_x5");
    cycle(1, 5, 42,  0, 0, ards(0, 5), "same_cycle_x5");
    cycle(0, 0, 0,   0, 0, ards(0, 5), "after_x5");

    cycle(0, 0, 0,   1, 3, ards(0, 0), "set_x3");
    cycle(0, 0, 0,   0, 0, ards(3, 0), "busy_x3");
    cycle(1, 3, 9,   0, 0, ards(3, 3), "clr_x3");
    cycle(0, 0, 0,   0, 0, ards(3, 0), "after_clr_x3");

    cycle(0, 0, 0,   1, 4, ards(0, 0), "set_x4");
    cycle(1, 4, 11,  1, 4, ards(4, 0), "collide_x4");
    cycle(0, 0, 0,   1, 0, ards(4, 4), "after_collide_set_x0");
    cycle(1, 4, 12,  0, 0, ards(0, 4), "clr_x4");

    cycle(0, 0, 0,   1, 2, ards(0, 0), "set_x2");
    cycle(1, 6, 55,  1, 6, ards(2, 0), "set_wr_x6");
    cycle(0, 0, 0,   0, 0, ards(6, 2), "pre_reset");
    cycle(1, 6, 77,  1, 7, ards(6, 2), "pre_reset_wr");
    async_reset("async_reset");
    cycle(0, 0, 0,   0, 0, ards(6, 2), "post_reset");

    for (int k = 0; k < 400; k++) begin
      for (int i = 0; i < NUM_RD; i++) ra[i*AW +: AW] = AW'($urandom_range(0, 7));
      if (k == 200) async_reset("rand_reset");
      else cycle($urandom_range(0, 1) == 1, $urandom_range(0, 7), XLEN'($urandom),
                 $urandom_range(0, 2) == 0, $urandom_range(0, 7), ra, "rand");
    end

    cycle(0, 0, 0, 0, 0, ards(0, 0), "idle");
    @(negedge clk);
    @(negedge clk);
    #1;
    check("queue_drained", 256'(q.size()), 256'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile_scoreboard.md
Name: regfile_scoreboard

Overview:
- Parametrised successor to the core's 2-read/1-write Register_File.
- Configurable data width, register count and read-port count.
- Per-register busy scoreboard: marks registers with an outstanding long-latency write (load/mul) and flags read hazards to the pipeline control.
- Sits in the ID stage of the pipelined RISC-V core, between the decoder/Sign_Extend and the hazard unit.

Parameters:
- XLEN, 32, data width of each register.
- NREG, 32, number of architectural registers (power of 2, >=2); register 0 is hardwired to zero.
- NUM_RD, 2, number of combinational read ports (1..4).
- AW, $clog2(NREG), address width (derived; not overridden).

Ports:
- clk  in  1  core clock; all state updates on rising edge.
- rst  in  1  asynchronous active-low reset.
- WE3  in  1  write enable for write port.
- A3  in  AW  write address.
- WD3  in  XLEN  write data.
- A_RD  in  NUM_RD*AW  packed read addresses; port i = bits [i*AW +: AW].
- RD  out  NUM_RD*XLEN  packed read data; port i = bits [i*XLEN +: XLEN].
- BUSY_SET  in  1  mark register A_BUSY as having a pending producer.
- A_BUSY  in  AW  register to mark busy.
- RD_BUSY  out  NUM_RD  per-port hazard flag: 1 = addressed register is busy.
- ANY_BUSY  out  1  OR of all scoreboard bits.
- BUSY_CNT  out  AW+1  number of busy registers.

Behaviour:
- Reset (rst=0, asynchronous):
  - All registers clear to 0; all busy bits clear.
  - RD reads 0 on every port; RD_BUSY=0, ANY_BUSY=0, BUSY_CNT=0.
  - Reset asserted mid-operation discards pending writes and busy marks immediately.
- Write: on a rising edge with rst=1, WE3=1 and A3!=0, reg[A3] <= WD3. Writes to register 0 are ignored; reg[0] always reads 0.
- Read: combinational, zero latency. RD port i = reg[A_RD_i]; address 0 -> 0.
  - Same-cycle write/read of the same register: see Optional Feature.
- Scoreboard, per register r (r != 0), on each rising edge:
  - set = BUSY_SET && A_BUSY==r.
  - clr = WE3 && A3==r.
  - set=1 -> busy[r] <= 1; set wins over a simultaneous clr (a new producer is issued in the same cycle the old one retires).
  - set=0, clr=1 -> busy[r] <= 0.
  - Otherwise busy[r] holds.
  - BUSY_SET on register 0 is ignored; busy[0] is constant 0.
- Write to a non-busy register is legal; busy stays 0.
- RD_BUSY[i] = busy[A_RD_i], combinational, from the registered busy state.
  - A clear landing this cycle is not visible until the next cycle unless REGFILE_BYPASS_EN is defined.
- BUSY_CNT = popcount(busy), registered-state based, range 0..NREG-1; it cannot wrap.
- ANY_BUSY = (BUSY_CNT != 0).
- No X propagation: out-of-range addresses cannot occur (AW exact); all outputs are defined every cycle after reset.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined: write-to-read forwarding.
  - If WE3=1, A3!=0 and A_RD_i==A3, RD port i returns WD3 in the same cycle.
  - RD_BUSY[i] is forced to 0 for that port, since the pending value arrives now; set-wins still applies to the registered busy bit.
- Not defined:
  - RD returns the pre-write (old) register value in the write cycle.
  - RD_BUSY[i] reflects the registered busy bit only.
  - The pipeline relies on write-first-half/read-second-half timing or on a one-cycle stall.

Test Plan:
- Reset then read: rst=0 for 10 ns, then rst=1; A_RD={x1,x0} -> RD={0,0}, RD_BUSY=0, BUSY_CNT=0.
- Write/read-back: WE3=1, A3=1, WD3=100; next cycle A_RD port0=1 -> RD0=100. WE3=1, A3=0, WD3=5 -> reg0 still reads 0.
- Same-cycle bypass: reg5=7; WE3=1, A3=5, WD3=42, A_RD port1=5 in the same cycle:
  - With REGFILE_BYPASS_EN -> RD1=42.
  - Without it -> RD1=7, then RD1=42 next cycle.
- Scoreboard set/clear: BUSY_SET, A_BUSY=3 -> next cycle RD_BUSY=1 when reading x3, BUSY_CNT=1. WE3, A3=3, WD3=9 -> busy clears, BUSY_CNT=0, RD=9.
- Set-wins collision: busy[4]=1; same edge BUSY_SET A_BUSY=4 and WE3 A3=4 WD3=11 -> reg4=11, busy[4] stays 1, BUSY_CNT unchanged.
- Async reset mid-operation: busy on x2 and x6, reg6=55; drop rst between clock edges -> immediately RD=0, BUSY_CNT=0, ANY_BUSY=0. Also rerun with NUM_RD=3, XLEN=64, NREG=16.
